// File: rtl/outerprodrc_bin2uni_enc_pkg.sv
// Shared definitions for the outer-product unary GEMM transmit-side encoder:
// default geometry, FSM state encoding and the low-discrepancy index scrambler.
package outerprodrc_bin2uni_enc_pkg;

  localparam int unsigned VECLEN_DEF   = 4;
  localparam int unsigned BITWIDTH_DEF = 8;
  localparam int unsigned CNTW_DEF     = BITWIDTH_DEF - 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Reverses the low w bits of x; bits at and above w come back as zero.
  function automatic logic [31:0] bit_rev(input logic [31:0] x, input int unsigned w);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < w) r[w-1-i] = x[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/outerprodrc_bin2uni_lane.sv
// One encoder lane: latches sign and saturated magnitude of a two's-complement
// element, then emits a registered unary bit by comparing against the window index.
module outerprodrc_bin2uni_lane #(
  parameter int unsigned BITWIDTH = 8,
  parameter int unsigned CNTW     = BITWIDTH - 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic                emit_i,
  input  logic [BITWIDTH-1:0] data_i,
  input  logic [CNTW-1:0]     rng_i,
  output logic                sign_o,
  output logic                bit_o
);

  logic            sign_d, sign_q;
  logic [CNTW-1:0] mag_d, mag_q;
  logic            sign_out_q, bit_q;

  // The most negative value has no positive twin in CNTW bits; saturate it.
  always_comb begin
    sign_d = data_i[BITWIDTH-1];
    if (data_i == {1'b1, {CNTW{1'b0}}}) begin
      mag_d = '1;
    end else if (sign_d) begin
      mag_d = (~data_i[CNTW-1:0]) + CNTW'(1);
    end else begin
      mag_d = data_i[CNTW-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sign_q     <= 1'b0;
      mag_q      <= '0;
      sign_out_q <= 1'b0;
      bit_q      <= 1'b0;
    end else begin
      if (load_i) begin
        sign_q <= sign_d;
        mag_q  <= mag_d;
      end
      sign_out_q <= emit_i & sign_q;
      bit_q      <= emit_i & (mag_q > rng_i);
    end
  end

  assign sign_o = sign_out_q;
  assign bit_o  = bit_q;

endmodule

// File: rtl/outerprodrc_bin2uni_enc.sv
// Binary-to-unary rate-coded encoder: accepts one signed vector, then streams
// 2^CNTW sign/bit cycles per element. Define OUTERPRODRC_ENC_BITREV_EN for bit-reversed ordering.
module outerprodrc_bin2uni_enc
  import outerprodrc_bin2uni_enc_pkg::*;
#(
  parameter int unsigned VECLEN   = VECLEN_DEF,
  parameter int unsigned BITWIDTH = BITWIDTH_DEF,
  parameter int unsigned CNTW     = BITWIDTH - 1
) (
  input  logic                       iClk,
  input  logic                       iRst,
  input  logic                       iValid,
  output logic                       oReady,
  input  logic [VECLEN*BITWIDTH-1:0] iData,
  input  logic                       iEn,
  input  logic                       iClr,
  output logic [VECLEN-1:0]          oSign,
  output logic [VECLEN-1:0]          oBit,
  output logic                       oValid,
  output logic                       oLast
);

  state_e          state_q;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CNTW-1:0] rng;
  logic            valid_q, last_q;
  logic            accept, emit, cnt_max;

  assign oReady  = (state_q == ST_IDLE);
  assign accept  = oReady & iValid & ~iClr;
  assign emit    = (state_q == ST_RUN) & iEn & ~iClr;
  assign cnt_max = &cnt_q;
  assign cnt_d   = cnt_q + CNTW'(1);

`ifdef OUTERPRODRC_ENC_BITREV_EN
  assign rng = CNTW'(bit_rev(32'(cnt_q), CNTW));
`else
  assign rng = cnt_q;
`endif

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (iClr) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          if (iValid) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
          end
        end
        ST_RUN: begin
          valid_q <= iEn;
          last_q  <= iEn & cnt_max;
          if (iEn) begin
            cnt_q <= cnt_d;
            // Wrapping past the last index closes the window.
            if (cnt_max) state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  for (genvar e = 0; e < VECLEN; e++) begin : g_lane
    outerprodrc_bin2uni_lane #(
      .BITWIDTH(BITWIDTH),
      .CNTW    (CNTW)
    ) u_lane (
      .clk_i (iClk),
      .rst_i (iRst),
      .load_i(accept),
      .emit_i(emit),
      .data_i(iData[e*BITWIDTH +: BITWIDTH]),
      .rng_i (rng),
      .sign_o(oSign[e]),
      .bit_o (oBit[e])
    );
  end

  assign oValid = valid_q;
  assign oLast  = last_q;

endmodule

// File: tb/tb_outerprodrc_bin2uni_enc.sv
// Directed bench for outerprodrc_bin2uni_enc (VECLEN=4, BITWIDTH=8): table-driven
// full windows plus stall, synchronous-clear and asynchronous-reset sequences.
module tb_outerprodrc_bin2uni_enc;

  localparam int L = 128;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iValid;
  logic        oReady;
  logic [31:0] iData;
  logic        iEn;
  logic        iClr;
  logic [3:0]  oSign;
  logic [3:0]  oBit;
  logic        oValid;
  logic        oLast;

  outerprodrc_bin2uni_enc dut (
    .iClk  (iClk),
    .iRst  (iRst),
    .iValid(iValid),
    .oReady(oReady),
    .iData (iData),
    .iEn   (iEn),
    .iClr  (iClr),
    .oSign (oSign),
    .oBit  (oBit),
    .oValid(oValid),
    .oLast (oLast)
  );

  always #5 iClk = ~iClk;

  typedef struct packed {
    logic [31:0]     data;
    logic [3:0][7:0] ones;
    logic [3:0]      sign;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int rev7(input int k);
    int r;
    r = 0;
    for (int i = 0; i < 7; i++) if (k[i]) r |= (1 << (6 - i));
    return r;
  endfunction

  function automatic logic exp_bit(input int k, input int ones);
`ifdef OUTERPRODRC_ENC_BITREV_EN
    return rev7(k) < ones;
`else
    return k < ones;
`endif
  endfunction

  // Window observation results.
  int   w_valid, w_last_idx, w_first, w_gap, w_timeout;
  int   w_ones[4];
  logic w_pat_err[4], w_sign_err[4];
  logic w_stall_err, w_ready_err, w_ready_pre, w_ready_post;

  task automatic run_window(input vec_t v, input int st_s, input int st_l);
    int n;
    w_valid = 0; w_last_idx = -1; w_first = -1; w_gap = 0; w_timeout = 0;
    w_stall_err = 1'b0; w_ready_err = 1'b0; w_ready_post = 1'b0;
    for (int e = 0; e < 4; e++) begin
      w_ones[e] = 0; w_pat_err[e] = 1'b0; w_sign_err[e] = 1'b0;
    end
    @(negedge iClk);
    w_ready_pre = oReady;
    iValid = 1'b1; iData = v.data; iEn = 1'b1;
    @(negedge iClk);
    iValid = 1'b0;
    n = 0;
    while (w_valid < L && n < 400) begin
      iEn = !(n >= st_s && n < st_s + st_l);
      @(negedge iClk);
      if (oValid) begin
        if (w_first < 0) w_first = n;
        for (int e = 0; e < 4; e++) begin
          if (oBit[e]) w_ones[e]++;
          if (oBit[e] != exp_bit(w_valid, int'(v.ones[e]))) w_pat_err[e] = 1'b1;
          if (oSign[e] != v.sign[e]) w_sign_err[e] = 1'b1;
        end
        if (oLast) w_last_idx = w_valid;
        if (w_valid < L - 1 && oReady) w_ready_err = 1'b1;
        if (w_valid == L - 1) w_ready_post = oReady;
        w_valid++;
      end else begin
        if (w_first >= 0) w_gap++;
        if (oBit != 4'b0 || oSign != 4'b0 || oLast) w_stall_err = 1'b1;
      end
      if (!iEn && oValid) w_stall_err = 1'b1;
      n++;
    end
    if (n >= 400) w_timeout = 1;
    iEn = 1'b1;
  endtask

  task automatic check_window(input string tag, input vec_t v, input int exp_first, input int exp_gap);
    check({tag, ".timeout"}, w_timeout, 0);
    check({tag, ".ready_pre"}, int'(w_ready_pre), 1);
    check({tag, ".valid_cnt"}, w_valid, L);
    check({tag, ".last_idx"}, w_last_idx, L - 1);
    check({tag, ".first"}, w_first, exp_first);
    check({tag, ".gap"}, w_gap, exp_gap);
    check({tag, ".stall_err"}, int'(w_stall_err), 0);
    check({tag, ".ready_during"}, int'(w_ready_err), 0);
    check({tag, ".ready_post"}, int'(w_ready_post), 1);
    for (int e = 0; e < 4; e++) begin
      check($sformatf("%s.ones%0d", tag, e), w_ones[e], int'(v.ones[e]));
      check($sformatf("%s.pattern%0d", tag, e), int'(w_pat_err[e]), 0);
      check($sformatf("%s.sign%0d", tag, e), int'(w_sign_err[e]), 0);
    end
  endtask

  vec_t vecs[4];

  initial begin
    int cnt;
    logic flag;

    // Elements packed e3..e0; expected ones = |x| with -128 saturated to 127.
    vecs[0] = '{data: {8'hFF, 8'd127, 8'd0, 8'd64},   ones: {8'd1, 8'd127, 8'd0, 8'd64},   sign: 4'b1000};
    vecs[1] = '{data: {8'd1, 8'hC0, 8'd5, 8'h80},     ones: {8'd1, 8'd64, 8'd5, 8'd127},   sign: 4'b0101};
    vecs[2] = '{data: 32'h0,                           ones: {8'd0, 8'd0, 8'd0, 8'd0},      sign: 4'b0000};
    vecs[3] = '{data: {8'd126, 8'hFE, 8'd100, 8'h81}, ones: {8'd126, 8'd2, 8'd100, 8'd127}, sign: 4'b0101};

    iRst = 1'b1; iValid = 1'b0; iData = '0; iEn = 1'b0; iClr = 1'b0;
    #12;
    check("rst.oValid", int'(oValid), 0);
    check("rst.oLast", int'(oLast), 0);
    check("rst.oBit", int'(oBit), 0);
    check("rst.oSign", int'(oSign), 0);
    check("rst.oReady", int'(oReady), 1);
    @(negedge iClk);
    iRst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      run_window(vecs[i], 1000, 0);
      check_window($sformatf("vec%0d", i), vecs[i], 0, 0);
    end

    // Five stalled cycles mid-window.
    run_window(vecs[0], 30, 5);
    check_window("stall", vecs[0], 0, 5);

    // Synchronous clear at RUN cycle 40 together with a new offer.
    @(negedge iClk);
    iValid = 1'b1; iData = vecs[0].data; iEn = 1'b1;
    @(negedge iClk);
    iValid = 1'b0;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge iClk);
      if (oValid) cnt++;
    end
    check("clr.pre_valid", cnt, 40);
    iClr = 1'b1; iValid = 1'b1; iData = vecs[1].data;
    @(negedge iClk);
    check("clr.oValid", int'(oValid), 0);
    check("clr.oBit", int'(oBit), 0);
    check("clr.oSign", int'(oSign), 0);
    check("clr.oLast", int'(oLast), 0);
    check("clr.oReady", int'(oReady), 1);
    iClr = 1'b0; iValid = 1'b0;
    flag = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge iClk);
      if (oValid || !oReady) flag = 1'b1;
    end
    check("clr.no_accept", int'(flag), 0);
    run_window(vecs[3], 1000, 0);
    check_window("after_clr", vecs[3], 0, 0);

    // Asynchronous reset between edges, mid-window.
    @(negedge iClk);
    iValid = 1'b1; iData = vecs[0].data; iEn = 1'b1;
    @(negedge iClk);
    iValid = 1'b0;
    repeat (20) @(negedge iClk);
    #2;
    check("arst.pre_valid", int'(oValid), 1);
    iRst = 1'b1;
    #1;
    check("arst.oValid", int'(oValid), 0);
    check("arst.oBit", int'(oBit), 0);
    check("arst.oSign", int'(oSign), 0);
    check("arst.oReady", int'(oReady), 1);
    @(negedge iClk);
    iRst = 1'b0;
    run_window(vecs[1], 1000, 0);
    check_window("after_arst", vecs[1], 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
